ss_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit seven-segment display.
//  - Holds a tear-free shadow copy of eight 4-bit digit codes.
//  - Steps the 3-bit digit select that drives the 8:1 digit mux.
//  - Drives the active-low anode strobes, with a guard (dead) interval per slot against ghosting.
//  - Sits between game/score logic (producer) and the mux + segment decoder.

---
 rtl/ss_pkg.sv | 23 ++
 rtl/ss_scan_ctrl_if.sv | 12 +
 rtl/ss_prescaler.sv | 31 +++
 rtl/ss_scan_ctrl.sv | 109 ++++++++++
 tb/tb_ss_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ss_pkg.sv
// Shared constants, FSM state type and helpers for the seven-segment scan controller.
// Optional leading-zero blanking is enabled by defining SS_LEADING_ZERO_BLANK_EN.
package ss_pkg;

  localparam int unsigned SS_DIGITS = 8;
  localparam int unsigned SS_SEL_W  = 3;
  localparam int unsigned SS_CODE_W = 4;
  localparam logic [SS_DIGITS-1:0] SS_AN_OFF = 8'hFF;

  typedef enum logic {
    SS_ST_GUARD = 1'b0,
    SS_ST_ON    = 1'b1
  } ss_state_t;

`ifdef SS_LEADING_ZERO_BLANK_EN
  // True when digit s and every higher digit are zero; digit 0 is never blanked.
  function automatic logic ss_blank(input logic [SS_DIGITS*SS_CODE_W-1:0] d,
                                    input logic [SS_SEL_W-1:0] s);
    return (s != '0) && ((d >> (SS_CODE_W * s)) == '0);
  endfunction
`endif

endpackage

// File: rtl/ss_scan_ctrl_if.sv
// Producer-side load handshake of the seven-segment scan controller.
interface ss_scan_ctrl_if;
  import ss_pkg::*;

  logic [SS_DIGITS*SS_CODE_W-1:0] digits_in;
  logic                           load;
  logic                           load_ack;

  modport master (output digits_in, output load, input load_ack);
  modport slave  (input digits_in, input load, output load_ack);

endinterface

// File: rtl/ss_prescaler.sv
// Digit-slot counter: counts 0..PRESCALE-1 while enabled, held at 0 when disabled.
module ss_prescaler #(
  parameter int unsigned PRESCALE = 12500,
  parameter int unsigned GUARD    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic slot_end,
  output logic guard_end
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  assign slot_end  = en && (cnt == CW'(PRESCALE - 1));
  assign guard_end = en && (cnt == CW'(GUARD - 1));

  // Slot counter: wraps at the end of each slot, cleared while scanning is off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ss_scan_ctrl.sv
// Seven-segment scan controller: digit select, registered anode strobes with a
// per-slot guard interval, and a frame-synchronous shadow register for the digit codes.
// Optional leading-zero blanking is enabled by defining SS_LEADING_ZERO_BLANK_EN.
module ss_scan_ctrl
  import ss_pkg::*;
#(
  parameter int unsigned PRESCALE = 12500,
  parameter int unsigned GUARD    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  ss_scan_ctrl_if.slave                  host,
  output logic [SS_DIGITS*SS_CODE_W-1:0] digits_q,
  output logic [SS_SEL_W-1:0]            sel,
  output logic [SS_DIGITS-1:0]           an,
  output logic                           frame_tick
);

  ss_state_t                      state_q, state_d;
  logic [SS_DIGITS-1:0]           an_d;
  logic                           slot_end, guard_end;
  logic                           boundary, apply;
  logic                           pending;
  logic                           load_ack_q;
  logic [SS_DIGITS*SS_CODE_W-1:0] staging;

  ss_prescaler #(
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .slot_end  (slot_end),
    .guard_end (guard_end)
  );

  // While the display is dark every cycle is treated as a boundary, so updates land at once.
  assign boundary      = slot_end && (sel == SS_SEL_W'(SS_DIGITS - 1));
  assign apply         = !en || boundary;
  assign host.load_ack = load_ack_q;

  // Next state and next anode pattern; the anodes are registered from this value.
  always_comb begin
    state_d = state_q;
    an_d    = SS_AN_OFF;
    if (!en) begin
      state_d = SS_ST_GUARD;
    end else begin
      case (state_q)
        SS_ST_GUARD: if (guard_end) state_d = SS_ST_ON;
        SS_ST_ON:    if (slot_end)  state_d = SS_ST_GUARD;
        default:     state_d = SS_ST_GUARD;
      endcase
    end
    // sel and digits_q cannot change on an edge that enters or stays in ON.
    if (state_d == SS_ST_ON) begin
      an_d = SS_AN_OFF ^ (SS_DIGITS'(1) << sel);
`ifdef SS_LEADING_ZERO_BLANK_EN
      if (ss_blank(digits_q, sel)) an_d = SS_AN_OFF;
`endif
    end
  end

  // Scan state: FSM register, anode strobes, digit select and frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SS_ST_GUARD;
      an         <= SS_AN_OFF;
      sel        <= '0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      an         <= an_d;
      frame_tick <= boundary;
      if (!en) begin
        sel <= '0;
      end else if (slot_end) begin
        sel <= sel + SS_SEL_W'(1);
      end
    end
  end

  // Load handshake: stage requests, publish to the shadow register only at frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q   <= '0;
      staging    <= '0;
      pending    <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= 1'b0;
      if (host.load && apply) begin
        digits_q   <= host.digits_in;
        pending    <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (apply && pending) begin
        digits_q   <= staging;
        pending    <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (host.load) begin
        staging <= host.digits_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Self-checking bench for ss_scan_ctrl with PRESCALE=20, GUARD=4 (default build, no blanking).
module tb_ss_scan_ctrl;

  localparam int P  = 20;
  localparam int G  = 4;
  localparam int FR = 8 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] digits_q;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic        frame_tick;

  ss_scan_ctrl_if bus_if ();

  ss_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .host       (bus_if.slave),
    .digits_q   (digits_q),
    .sel        (sel),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: t = enabled cycles since reset / last en=0 cycle.
  int          t;
  logic [31:0] mq, mstage;
  logic        mpend, mack;

  function automatic logic [7:0] exp_an();
    int slot = (t / P) % 8;
    if ((t % P) < G) return 8'hFF;
    return ~(8'h01 << slot);
  endfunction

  function automatic logic [2:0] exp_sel();
    return 3'((t / P) % 8);
  endfunction

  function automatic logic exp_tick();
    return (t > 0) && (t % FR == 0);
  endfunction

  task automatic model_reset();
    t = 0; mq = '0; mstage = '0; mpend = 1'b0; mack = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [31:0] d);
    logic apply_now;
    apply_now = !e || (t % FR == FR - 1);
    mack = 1'b0;
    if (l && apply_now) begin
      mq = d; mpend = 1'b0; mack = 1'b1;
    end else if (apply_now && mpend) begin
      mq = mstage; mpend = 1'b0; mack = 1'b1;
    end else if (l) begin
      mstage = d; mpend = 1'b1;
    end
    t = e ? t + 1 : 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    chk("m_an", 32'(an), 32'(exp_an()));
    chk("m_sel", 32'(sel), 32'(exp_sel()));
    chk("m_tick", 32'(frame_tick), 32'(exp_tick()));
    chk("m_q", digits_q, mq);
    chk("m_ack", 32'(bus_if.load_ack), 32'(mack));
  endtask

  // Drive inputs for the current cycle, clock once, then check at the falling edge.
  task automatic step(input logic e, input logic l, input logic [31:0] d);
    en = e; bus_if.load = l; bus_if.digits_in = d;
    @(posedge clk);
    model_edge(e, l, d);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step(1'b1, 1'b0, 32'h0);
  endtask

  typedef struct {
    int          cyc;
    logic        load;
    logic [31:0] din;
    logic [7:0]  an;
    logic [2:0]  sel;
    logic        tick;
    logic [31:0] q;
    logic        ack;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int acks;
    logic        nxt_load;
    logic [31:0] nxt_din;

    tbl[0]  = '{0,   1'b0, 32'h0,        8'hFF, 3'd0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{3,   1'b0, 32'h0,        8'hFF, 3'd0, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{4,   1'b0, 32'h0,        8'hFE, 3'd0, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{19,  1'b0, 32'h0,        8'hFE, 3'd0, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{20,  1'b0, 32'h0,        8'hFF, 3'd1, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{24,  1'b0, 32'h0,        8'hFD, 3'd1, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{50,  1'b1, 32'h87654321, 8'hFB, 3'd2, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{51,  1'b0, 32'h0,        8'hFB, 3'd2, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{159, 1'b0, 32'h0,        8'h7F, 3'd7, 1'b0, 32'h0,        1'b0};
    tbl[9]  = '{160, 1'b0, 32'h0,        8'hFF, 3'd0, 1'b1, 32'h87654321, 1'b1};
    tbl[10] = '{161, 1'b0, 32'h0,        8'hFF, 3'd0, 1'b0, 32'h87654321, 1'b0};

    rst = 1'b1; en = 1'b0; bus_if.load = 1'b0; bus_if.digits_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_q", digits_q, 32'h0);
    rst = 1'b0;
    cyc = 0;
    check_all();

    // Reset release with scanning enabled, plus a mid-frame load at cycle 50.
    nxt_load = 1'b0; nxt_din = '0;
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) begin
        step(1'b1, nxt_load, nxt_din);
        nxt_load = 1'b0; nxt_din = '0;
      end
      chk("tbl_an", 32'(an), 32'(tbl[i].an));
      chk("tbl_sel", 32'(sel), 32'(tbl[i].sel));
      chk("tbl_tick", 32'(frame_tick), 32'(tbl[i].tick));
      chk("tbl_q", digits_q, tbl[i].q);
      chk("tbl_ack", 32'(bus_if.load_ack), 32'(tbl[i].ack));
      nxt_load = tbl[i].load; nxt_din = tbl[i].din;
    end

    // Two loads in one frame: newest wins, single ack at the boundary.
    run_to(200);
    step(1'b1, 1'b1, 32'h11111111);
    run_to(250);
    step(1'b1, 1'b1, 32'h22222222);
    run_to(319);
    chk("t3_hold", digits_q, 32'h87654321);
    step(1'b1, 1'b0, 32'h0);
    chk("t3_q", digits_q, 32'h22222222);
    chk("t3_ack", 32'(bus_if.load_ack), 32'h1);
    acks = 0;
    while (cyc < 330) begin
      step(1'b1, 1'b0, 32'h0);
      if (bus_if.load_ack) acks++;
    end
    chk("t3_extra_ack", 32'(acks), 32'h0);

    // Load in the boundary cycle itself.
    run_to(479);
    chk("t4_sel7", 32'(sel), 32'h7);
    step(1'b1, 1'b1, 32'hA5A5A5A5);
    chk("t4_q", digits_q, 32'hA5A5A5A5);
    chk("t4_ack", 32'(bus_if.load_ack), 32'h1);
    acks = 0;
    while (cyc < 641) begin
      step(1'b1, 1'b0, 32'h0);
      if (bus_if.load_ack) acks++;
    end
    chk("t4_no_second_ack", 32'(acks), 32'h0);

    // en dropped mid-slot at sel=3, load while dark, then restart.
    run_to(710);
    chk("t5_sel3", 32'(sel), 32'h3);
    chk("t5_an3", 32'(an), 32'hF7);
    step(1'b0, 1'b0, 32'h0);
    chk("t5_dark_an", 32'(an), 32'hFF);
    chk("t5_dark_sel", 32'(sel), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h5A5A0000);
    chk("t5_dark_q", digits_q, 32'h5A5A0000);
    chk("t5_dark_ack", 32'(bus_if.load_ack), 32'h1);
    for (int k = 0; k < G; k++) begin
      chk("t5_guard", 32'(an), 32'hFF);
      step(1'b1, 1'b0, 32'h0);
    end
    chk("t5_restart_an", 32'(an), 32'hFE);
    chk("t5_restart_sel", 32'(sel), 32'h0);

    // Randomized traffic; odd chunks also toggle en.
    for (int chunk = 0; chunk < 8; chunk++) begin
      for (int k = 0; k < 400; k++) begin
        logic e, l;
        e = (chunk % 2 == 0) ? 1'b1 : ($urandom_range(0, 99) >= 4);
        l = ($urandom_range(0, 99) < 6);
        step(e, l, $urandom);
      end
    end

    // Reset mid-frame with a load just issued: everything clears, no ack afterwards.
    run_to(cyc + 30);
    step(1'b1, 1'b1, 32'hDEADBEEF);
    bus_if.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_an", 32'(an), 32'hFF);
    chk("mrst_sel", 32'(sel), 32'h0);
    chk("mrst_q", digits_q, 32'h0);
    chk("mrst_ack", 32'(bus_if.load_ack), 32'h0);
    chk("mrst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
    acks = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (bus_if.load_ack) acks++;
    end
    chk("mrst_no_ack", 32'(acks), 32'h0);
    chk("mrst_q_after", digits_q, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
